// File: rtl/uart_tx_pkg.sv
// Shared constants and types for the memory-mapped UART transmitter.
package uart_tx_pkg;

  localparam logic [1:0] REG_DATA    = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_DIVISOR = 2'd2;
  localparam logic [1:0] REG_CTRL    = 2'd3;

  localparam int ST_FULL      = 0;
  localparam int ST_EMPTY     = 1;
  localparam int ST_BUSY      = 2;
  localparam int ST_COUNT_LSB = 8;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

endpackage

// File: rtl/uart_tx_device_fifo.sv
// Circular byte FIFO with a show-ahead head output.
module byte_fifo #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [7:0]    din,
  input  logic          pop,
  output logic [7:0]    dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr, rptr;

  assign dout  = mem[rptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  always_ff @(posedge clk)
    if (push) mem[wptr] <= din;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end

endmodule

// File: rtl/uart_tx_device.sv
// Bus-attached 8N1 UART transmitter: register decode, FIFO and serialiser.
module uart_tx_device
  import uart_tx_pkg::*;
#(
  parameter int FIFO_DEPTH      = 16,
  parameter int DIVISOR_WIDTH   = 16,
  parameter int DEFAULT_DIVISOR = 868
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  input  logic [31:0] address,
  input  logic [3:0]  wstrobe,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        irq,
  output logic        tx
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [DIVISOR_WIDTH-1:0] ONE = DIVISOR_WIDTH'(1);

  logic [1:0]    sel;
  logic          is_wr, data_wr, push, pop;
  logic          fifo_full, fifo_empty;
  logic [7:0]    fifo_dout;
  logic [CW-1:0] fifo_count;

  logic [DIVISOR_WIDTH-1:0] divisor, dlat, divcnt;
  logic                     irq_en;
  tx_state_t                state;
  logic [7:0]               shreg;
  logic [2:0]               bitcnt;
  logic                     bit_end;
  logic                     unused_ok;

  assign unused_ok = ^{address, wdata};

  assign sel     = address[3:2];
  assign is_wr   = |wstrobe;
  assign data_wr = valid && is_wr && (sel == REG_DATA);
  // A full FIFO holds off DATA writes; everything else completes at once.
  assign ready   = valid && !(data_wr && fifo_full);
  assign push    = data_wr && ready && wstrobe[0];
  assign pop     = (state == IDLE) && !fifo_empty;
  assign bit_end = (divcnt == dlat - ONE);

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (wdata[7:0]),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    rdata = '0;
    if (ready && !is_wr)
      case (sel)
        REG_STATUS: begin
          rdata[ST_FULL]              = fifo_full;
          rdata[ST_EMPTY]             = fifo_empty;
          rdata[ST_BUSY]              = (state != IDLE);
          rdata[ST_COUNT_LSB +: CW]   = fifo_count;
        end
        REG_DIVISOR: rdata[DIVISOR_WIDTH-1:0] = divisor;
        REG_CTRL:    rdata[0]                 = irq_en;
        default:     ;
      endcase
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      divisor <= DIVISOR_WIDTH'(DEFAULT_DIVISOR);
      irq_en  <= 1'b0;
      irq     <= 1'b0;
    end else begin
      irq <= irq_en && fifo_empty;
      if (valid && ready && is_wr)
        case (sel)
          REG_DIVISOR:
            for (int i = 0; i < DIVISOR_WIDTH; i++)
              if (wstrobe[i/8]) divisor[i] <= wdata[i];
          REG_CTRL: if (wstrobe[0]) irq_en <= wdata[0];
          default: ;
        endcase
    end

  // tx is set one state ahead so that it is a flop matching the current state.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state  <= IDLE;
      tx     <= 1'b1;
      shreg  <= '0;
      bitcnt <= '0;
      divcnt <= '0;
      dlat   <= ONE;
    end else
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (!fifo_empty) begin
            shreg  <= fifo_dout;
            dlat   <= (divisor == '0) ? ONE : divisor;
            divcnt <= '0;
            tx     <= 1'b0;
            state  <= START;
          end
        end
        START:
          if (bit_end) begin
            divcnt <= '0;
            bitcnt <= '0;
            tx     <= shreg[0];
            state  <= DATA;
          end else divcnt <= divcnt + ONE;
        DATA:
          if (bit_end) begin
            divcnt <= '0;
            if (bitcnt == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bitcnt <= bitcnt + 3'd1;
              shreg  <= {1'b0, shreg[7:1]};
              tx     <= shreg[1];
            end
          end else divcnt <= divcnt + ONE;
        STOP:
          if (bit_end) begin
            divcnt <= '0;
            state  <= IDLE;
          end else divcnt <= divcnt + ONE;
        default: state <= IDLE;
      endcase

endmodule

// File: tb/tb_uart_tx_device.sv
// Scoreboarded bench: bus tasks push expected bytes, a tx monitor decodes frames.
module tb_uart_tx_device;
  import uart_tx_pkg::*;

  logic        clk = 1'b0, reset = 1'b0, valid = 1'b0;
  logic [31:0] address = '0, wdata = '0;
  logic [3:0]  wstrobe = '0;
  logic [31:0] rdata;
  logic        ready, irq, tx;

  always #5 clk = ~clk;

  uart_tx_device #(.FIFO_DEPTH(16), .DIVISOR_WIDTH(16), .DEFAULT_DIVISOR(868)) dut (
    .clk(clk), .reset(reset), .valid(valid), .address(address), .wstrobe(wstrobe),
    .wdata(wdata), .rdata(rdata), .ready(ready), .irq(irq), .tx(tx)
  );

  int         vectors = 0, miscompares = 0;
  logic [7:0] sb[$];
  int         mon_div = 868;
  int         frames_done = 0, exp_frames = 0;
  longint     last_start = -100000, min_gap = 64'd1 << 40;

  // tx monitor: every sample of a frame must match the expected 8N1 waveform.
  initial begin : monitor
    logic [7:0] exp_b;
    bit has_exp, bad, ab, e;
    int d, bi;
    forever begin
      @(negedge clk);
      if (reset && tx === 1'b0) begin
        d = mon_div;
        if ($time - last_start < min_gap) min_gap = $time - last_start;
        last_start = $time;
        has_exp = (sb.size() > 0);
        exp_b = has_exp ? sb.pop_front() : 8'h00;
        if (!has_exp) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_frame: start bit at %0t, expected no frame", $time);
        end
        bad = 0; ab = 0;
        for (int k = 0; k < 10 * d; k++) begin
          if (k > 0) @(negedge clk);
          if (!reset) begin ab = 1; break; end
          bi = k / d;
          e = (bi == 0) ? 1'b0 : (bi == 9) ? 1'b1 : exp_b[bi-1];
          if (tx !== e) bad = 1;
        end
        if (!ab) begin
          frames_done++;
          if (has_exp) begin
            vectors++;
            if (bad) begin
              miscompares++;
              $display("FAIL frame: tx waveform wrong, expected byte %02h at %0d cycles/bit", exp_b, d);
            end
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  task automatic bus_write(input logic [1:0] rs, input logic [3:0] strb, input logic [31:0] d,
                           output int stalls);
    address = {28'd0, rs, 2'b00}; wstrobe = strb; wdata = d; valid = 1'b1; stalls = 0;
    #1;
    while (!ready) begin
      @(negedge clk); #1; stalls++;
      if (stalls > 2000) begin
        vectors++; miscompares++;
        $display("FAIL write_timeout: ready=%0b after %0d cycles, expected 1", ready, stalls);
        break;
      end
    end
    @(posedge clk); @(negedge clk);
    valid = 1'b0; wstrobe = '0;
  endtask

  task automatic bus_read(input logic [1:0] rs, output logic [31:0] d);
    address = {28'd0, rs, 2'b00}; wstrobe = '0; valid = 1'b1;
    #1;
    d = ready ? rdata : 32'hDEAD_BEEF;
    @(posedge clk); @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic wait_frames(input int budget);
    int n = 0;
    while (frames_done < exp_frames && n < budget) begin @(negedge clk); n++; end
    vectors++;
    if (frames_done != exp_frames) begin
      miscompares++;
      $display("FAIL frames_done: got %0d, expected %0d", frames_done, exp_frames);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] r;
    repeat (3) @(negedge clk);
    vectors++;
    if (tx !== 1'b1 || irq !== 1'b0 || ready !== 1'b0 || rdata !== 32'd0) begin
      miscompares++;
      $display("FAIL in_reset: tx=%b irq=%b ready=%b rdata=%h, expected 1 0 0 0", tx, irq, ready, rdata);
    end
    reset = 1'b1;
    @(negedge clk);
    bus_read(REG_STATUS, r);
    vectors++; if (r !== 32'h2) begin miscompares++; $display("FAIL reset_status: got %h, expected 00000002", r); end
    bus_read(REG_DIVISOR, r);
    vectors++; if (r !== 32'd868) begin miscompares++; $display("FAIL reset_divisor: got %0d, expected 868", r); end
    bus_read(REG_CTRL, r);
    vectors++; if (r !== 32'd0) begin miscompares++; $display("FAIL reset_ctrl: got %h, expected 0", r); end
    bus_read(REG_DATA, r);
    vectors++; if (r !== 32'd0) begin miscompares++; $display("FAIL data_read: got %h, expected 0", r); end
    vectors++;
    if (tx !== 1'b1 || irq !== 1'b0) begin
      miscompares++; $display("FAIL idle_pins: tx=%b irq=%b, expected 1 0", tx, irq);
    end
  endtask

  task automatic test_single_frame();
    logic [31:0] r; int st;
    bus_write(REG_DIVISOR, 4'b0011, 32'd4, st); mon_div = 4;
    sb.push_back(8'h41); exp_frames++;
    bus_write(REG_DATA, 4'b0001, 32'h41, st);
    repeat (3) @(negedge clk);
    bus_read(REG_STATUS, r);
    vectors++; if (r !== 32'h6) begin miscompares++; $display("FAIL busy_status: got %h, expected 00000006", r); end
    wait_frames(200);
    bus_read(REG_STATUS, r);
    vectors++; if (r !== 32'h2) begin miscompares++; $display("FAIL done_status: got %h, expected 00000002", r); end
  endtask

  task automatic test_fifo_fill();
    logic [31:0] r; int st, early;
    logic [7:0] b;
    bus_write(REG_DIVISOR, 4'b0001, 32'd2, st); mon_div = 2;
    min_gap = 64'd1 << 40; early = 0;
    for (int i = 0; i < 18; i++) begin
      b = 8'(i * 37 + 5);
      sb.push_back(b); exp_frames++;
      bus_write(REG_DATA, 4'b0001, {24'd0, b}, st);
      if (i < 17 && st != 0) early++;
    end
    // first pop at P2, next pop a full frame plus one idle cycle later
    vectors++; if (st !== 6) begin miscompares++; $display("FAIL full_stall: got %0d cycles, expected 6", st); end
    vectors++; if (early !== 0) begin miscompares++; $display("FAIL early_stall: got %0d stalled writes, expected 0", early); end
    wait_frames(800);
    vectors++; if (min_gap !== 210) begin miscompares++; $display("FAIL frame_gap: got %0d ns, expected 210", min_gap); end
    bus_read(REG_STATUS, r);
    vectors++; if (r !== 32'h2) begin miscompares++; $display("FAIL fill_status: got %h, expected 00000002", r); end
  endtask

  task automatic test_irq();
    logic [31:0] r; int st, n;
    bus_write(REG_CTRL, 4'b0001, 32'd1, st);
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_latency: got %b, expected 0", irq); end
    @(negedge clk);
    vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL irq_set: got %b, expected 1", irq); end
    sb.push_back(8'h5A); sb.push_back(8'hC3); exp_frames += 2;
    bus_write(REG_DATA, 4'b0001, 32'h5A, st);
    bus_write(REG_DATA, 4'b0001, 32'hC3, st);
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_clear: got %b, expected 0", irq); end
    n = 0;
    while (irq !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    vectors++; if (n !== 22) begin miscompares++; $display("FAIL irq_reassert: after %0d cycles, expected 22", n); end
    bus_read(REG_STATUS, r);
    vectors++; if (r[ST_EMPTY] !== 1'b1) begin miscompares++; $display("FAIL irq_empty: got %h, expected empty bit set", r); end
    wait_frames(200);
    bus_write(REG_CTRL, 4'b0001, 32'd0, st);
    @(negedge clk);
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_disable: got %b, expected 0", irq); end
  endtask

  task automatic test_div_zero();
    logic [31:0] r; int st;
    bus_write(REG_DIVISOR, 4'b0011, 32'd0, st); mon_div = 1;
    bus_read(REG_DIVISOR, r);
    vectors++; if (r !== 32'd0) begin miscompares++; $display("FAIL div_zero_read: got %0d, expected 0", r); end
    sb.push_back(8'hFF); exp_frames++;
    bus_write(REG_DATA, 4'b0001, 32'hFF, st);
    wait_frames(100);
  endtask

  task automatic test_reset_midframe();
    logic [31:0] r; int st, n, hi_bad, fd;
    bus_write(REG_DIVISOR, 4'b0011, 32'd4, st); mon_div = 4;
    for (int i = 0; i < 3; i++) begin
      sb.push_back(8'h00); exp_frames++;
      bus_write(REG_DATA, 4'b0001, 32'h00, st);
    end
    n = 0;
    while (tx !== 1'b0 && n < 50) begin @(negedge clk); n++; end
    repeat (8) @(negedge clk);
    vectors++; if (tx !== 1'b0) begin miscompares++; $display("FAIL midframe_tx: got %b, expected 0", tx); end
    #2 reset = 1'b0;
    #1;
    vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL async_reset_tx: got %b, expected 1", tx); end
    repeat (3) @(negedge clk);
    sb.delete(); exp_frames = frames_done; fd = frames_done;
    reset = 1'b1;
    @(negedge clk);
    bus_read(REG_STATUS, r);
    vectors++; if (r !== 32'h2) begin miscompares++; $display("FAIL post_reset_status: got %h, expected 00000002", r); end
    hi_bad = 0;
    repeat (100) begin @(negedge clk); if (tx !== 1'b1) hi_bad++; end
    vectors++;
    if (hi_bad !== 0 || frames_done !== fd) begin
      miscompares++;
      $display("FAIL flushed: %0d low samples, %0d frames, expected 0 and 0", hi_bad, frames_done - fd);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_fifo_fill();
    test_irq();
    test_div_zero();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
